// File: rtl/router_pkg.sv
// Shared router definitions: packet/link geometry, rx FSM states and the
// buffer-select encodings used by the buffer controller and its feeders.
package router_pkg;

  localparam int unsigned PKT_W       = 55;
  localparam int unsigned LINK_W      = 8;
  localparam int unsigned FRAME_BYTES = 7;
  localparam int unsigned FRAME_W     = LINK_W * FRAME_BYTES;
  localparam int unsigned PARITY_IDX  = 55;
  localparam int unsigned CNT_W       = $clog2(FRAME_BYTES + 1);

  typedef enum logic [0:0] {
    StIdle,
    StAssemble
  } rx_state_e;

  typedef enum logic [1:0] {
    BufSelHold = 2'd0,
    BufSelProc = 2'd1,
    BufSelRx   = 2'd2
  } buf_sel_e;

  // Even parity over the whole frame: result is 1 when the frame is bad.
  function automatic logic frame_parity_bad(input logic [FRAME_W-1:0] frame);
    return frame[PARITY_IDX] ^ (^frame[PKT_W-1:0]);
  endfunction

endpackage

// File: rtl/link_rx_deframer_if.sv
// Link-side byte stream plus the rx packet handshake towards the buffer controller.
interface link_rx_deframer_if;
  import router_pkg::*;

  logic              link_valid;
  logic              link_sof;
  logic [LINK_W-1:0] link_data;
  logic              rx_ack;
  logic [PKT_W-1:0]  from_rx;
  logic              rx_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  // Master: link driver / buffer controller side.
  modport master (
    output link_valid, link_sof, link_data, rx_ack,
    input  from_rx, rx_valid, parity_err, frame_err, overrun
  );

  // Slave: the deframer.
  modport slave (
    input  link_valid, link_sof, link_data, rx_ack,
    output from_rx, rx_valid, parity_err, frame_err, overrun
  );

endinterface

// File: rtl/rx_gap_timer.sv
// Idle-gap counter: counts increment requests, fires timeout on the request
// that would bring the count to Timeout, then self-clears.
module rx_gap_timer #(
  parameter int unsigned Timeout = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(Timeout + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_o = inc_i && !clr_i && (cnt_q == CntW'(Timeout - 1));

  // Next count: clear wins, timeout restarts from zero, otherwise count idles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || timeout_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/link_rx_deframer.sv
// Link receive deframer: reassembles 7-byte frames into 55-bit packets,
// checks even parity and offers good packets to the buffer controller.
module link_rx_deframer
  import router_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  link_rx_deframer_if.slave bus
);

  // Only the first six bytes need storing; the seventh completes the frame
  // straight from the link.
  localparam int unsigned SR_W = FRAME_W - LINK_W;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [PKT_W-1:0]  from_rx_q, from_rx_d;
  logic              rx_valid_q, rx_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic [FRAME_W-1:0] frame_next;
  logic               gap_clr;
  logic               gap_inc;
  logic               gap_timeout;

  assign frame_next = {sr_q, bus.link_data};
  assign gap_clr    = bus.link_valid || (state_q == StIdle);
  assign gap_inc    = (state_q == StAssemble) && !bus.link_valid;

  rx_gap_timer #(
    .Timeout (GAP_TIMEOUT)
  ) u_gap_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (gap_clr),
    .inc_i     (gap_inc),
    .timeout_o (gap_timeout)
  );

  // Next-state for the frame FSM, shift register, packet holding register and pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    from_rx_d    = from_rx_q;
    rx_valid_d   = rx_valid_q && !bus.rx_ack;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.link_valid) begin
          if (bus.link_sof) begin
            sr_d    = SR_W'(bus.link_data);
            cnt_d   = CNT_W'(1);
            state_d = StAssemble;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      StAssemble: begin
        if (bus.link_valid) begin
          if (bus.link_sof) begin
            // Restart with this byte as byte 1.
            frame_err_d = 1'b1;
            sr_d        = SR_W'(bus.link_data);
            cnt_d       = CNT_W'(1);
          end else if (cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = StIdle;
            if (frame_parity_bad(frame_next)) begin
              parity_err_d = 1'b1;
            end else if (!rx_valid_q || bus.rx_ack) begin
              from_rx_d  = frame_next[PKT_W-1:0];
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            sr_d  = frame_next[SR_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (gap_timeout) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Frame FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sr_q         <= '0;
      from_rx_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      from_rx_q    <= from_rx_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.from_rx    = from_rx_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule
